// File: rtl/snn_param_bank_memory_pkg.sv
// Shared types and elaboration helpers for the double-buffered SNN parameter memory.
package snn_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOADING,
        LOADED
    } state_t;

    localparam int DEF_M  = 10;
    localparam int DEF_N  = 8;
    localparam int DEF_W  = 8;
    localparam int CHUNKS = DEF_N / DEF_W;
    localparam int AW     = $clog2(DEF_M);

    function automatic int chunks_of(input int n, input int w);
        return n / w;
    endfunction

    // A word must split into whole stream chunks.
    function automatic bit n_multiple_of_w(input int n, input int w);
        return (w > 0) && (n >= w) && ((n % w) == 0);
    endfunction

endpackage

// File: rtl/snn_param_bank_memory_if.sv
// Load-stream handshake between the config front end and the parameter memory.
interface snn_param_bank_memory_if #(
    parameter int W = 8
);
    logic         load_start;
    logic [W-1:0] load_data;
    logic         load_valid;
    logic         load_ready;

    modport master (
        output load_start,
        output load_data,
        output load_valid,
        input  load_ready
    );

    modport slave (
        input  load_start,
        input  load_data,
        input  load_valid,
        output load_ready
    );
endinterface

// File: rtl/snn_param_bank_memory_assembler.sv
// Collects W-bit chunks LSB-first into N-bit words; word is valid on the final chunk.
module snn_word_assembler
    import snn_mem_pkg::*;
#(
    parameter int N = 8,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         clear,
    input  logic         accept,
    input  logic [W-1:0] data,
    output logic [N-1:0] word,
    output logic         word_valid
);
    localparam int NCH = chunks_of(N, W);
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

    logic [CW-1:0] chunk_cnt_reg;
    logic [CW-1:0] chunk_cnt_next;
    logic [N-1:0]  asm_reg;
    logic [N-1:0]  asm_next;
    logic          last_chunk;
    logic          take;

    assign take       = accept && !clear;
    assign last_chunk = (chunk_cnt_reg == CW'(NCH - 1));
    assign word_valid = take && last_chunk;

    // The incoming chunk drops into its slot combinationally, so the
    // completed word is available on the same edge that accepts it.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_slot
            assign asm_next[gi*W +: W] = (take && (chunk_cnt_reg == CW'(gi)))
                                         ? data : asm_reg[gi*W +: W];
        end
    endgenerate

    assign word = asm_next;

    always_comb begin
        chunk_cnt_next = chunk_cnt_reg;
        if (take) begin
            chunk_cnt_next = last_chunk ? '0 : chunk_cnt_reg + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (srst || clear) begin
            chunk_cnt_reg <= '0;
            asm_reg       <= '0;
        end else begin
            chunk_cnt_reg <= chunk_cnt_next;
            asm_reg       <= word_valid ? '0 : asm_next;
        end
    end

endmodule

// File: rtl/snn_param_bank_memory.sv
// Shadow/active parameter banks: stream-loaded shadow, single-cycle commit to active.
module snn_param_bank_memory
    import snn_mem_pkg::*;
#(
    parameter int M = 10,
    parameter int N = 8,
    parameter int W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    snn_param_bank_memory_if.slave   ld,
    input  logic                     commit,
    input  logic [$clog2(M)-1:0]     addr,
    output logic [N-1:0]             data_out,
    output logic [M*N-1:0]           all_data_out,
    output logic [$clog2(M+1)-1:0]   load_count,
    output logic                     load_done,
    output logic                     overflow_err
);
    localparam int PW = $clog2(M + 1);

    generate
        if (!n_multiple_of_w(N, W) || (M < 2)) begin : g_param_check
            $error("snn_param_bank_memory: need M >= 2 and N a multiple of W");
        end
    endgenerate

    state_t        state_reg, state_next;
    logic [PW-1:0] word_ptr_reg, word_ptr_next;
    logic          overflow_reg, overflow_next;
    logic          commit_fire;
    logic          accept;
    logic [N-1:0]  word;
    logic          word_valid;

    logic [N-1:0]  shadow_reg [M];
    logic [N-1:0]  active_reg [M];

    // A same-cycle restart wins over the chunk on the bus.
    assign accept = (state_reg == LOADING) && ld.load_valid && !ld.load_start;

    snn_word_assembler #(.N(N), .W(W)) u_asm (
        .clk        (clk),
        .srst       (reset),
        .clear      (ld.load_start),
        .accept     (accept),
        .data       (ld.load_data),
        .word       (word),
        .word_valid (word_valid)
    );

    always_comb begin
        state_next    = state_reg;
        word_ptr_next = word_ptr_reg;
        overflow_next = overflow_reg;
        commit_fire   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (ld.load_start) begin
                    state_next    = LOADING;
                    word_ptr_next = '0;
                end
            end
            LOADING: begin
                if (ld.load_start) begin
                    word_ptr_next = '0;
                end else if (word_valid) begin
                    word_ptr_next = word_ptr_reg + PW'(1);
                    if (word_ptr_reg == PW'(M - 1)) begin
                        state_next = LOADED;
                    end
                end
            end
            LOADED: begin
                if (ld.load_valid) begin
                    overflow_next = 1'b1;
                end
                if (commit) begin
                    commit_fire   = 1'b1;
                    state_next    = IDLE;
                    word_ptr_next = '0;
                end
                if (ld.load_start) begin
                    state_next    = LOADING;
                    word_ptr_next = '0;
                end
            end
            default: begin
                state_next    = IDLE;
                word_ptr_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            word_ptr_reg <= '0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            word_ptr_reg <= word_ptr_next;
            overflow_reg <= overflow_next;
        end
    end

    generate
        for (genvar gi = 0; gi < M; gi++) begin : g_bank
            always_ff @(posedge clk) begin
                if (reset) begin
                    shadow_reg[gi] <= '0;
                    active_reg[gi] <= '0;
                end else begin
                    if (word_valid && (word_ptr_reg == PW'(gi))) begin
                        shadow_reg[gi] <= word;
                    end
                    if (commit_fire) begin
                        active_reg[gi] <= shadow_reg[gi];
                    end
                end
            end
            assign all_data_out[gi*N +: N] = active_reg[gi];
        end
    endgenerate

    always_comb begin
        data_out = '0;
        if (32'(addr) < M) begin
            data_out = active_reg[addr];
        end
    end

    assign ld.load_ready  = (state_reg == LOADING);
    assign load_done      = (state_reg == LOADED);
    assign load_count     = word_ptr_reg;
    assign overflow_err   = overflow_reg;

endmodule

// File: tb/tb_snn_param_bank_memory.sv
// Directed bench: one 4x16 instance (W=8) and one 10x8 instance (W=8).
module tb_snn_param_bank_memory;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: M=4, N=16, W=8
    logic        reset_a, commit_a, done_a, ovf_a;
    logic [1:0]  addr_a;
    logic [15:0] dout_a;
    logic [63:0] all_a;
    logic [2:0]  count_a;
    // Instance B: M=10, N=8, W=8
    logic        reset_b, commit_b, done_b, ovf_b;
    logic [3:0]  addr_b;
    logic [7:0]  dout_b;
    logic [79:0] all_b;
    logic [3:0]  count_b;

    snn_param_bank_memory_if #(.W(8)) if_a ();
    snn_param_bank_memory_if #(.W(8)) if_b ();

    snn_param_bank_memory #(.M(4), .N(16), .W(8)) dut_a (
        .clk(clk), .reset(reset_a), .ld(if_a), .commit(commit_a), .addr(addr_a),
        .data_out(dout_a), .all_data_out(all_a), .load_count(count_a),
        .load_done(done_a), .overflow_err(ovf_a)
    );

    snn_param_bank_memory #(.M(10), .N(8), .W(8)) dut_b (
        .clk(clk), .reset(reset_b), .ld(if_b), .commit(commit_b), .addr(addr_b),
        .data_out(dout_b), .all_data_out(all_b), .load_count(count_b),
        .load_done(done_b), .overflow_err(ovf_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [7:0] d);
        if_a.load_valid = 1'b1;
        if_a.load_data  = d;
        tick();
        if_a.load_valid = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] d);
        if_b.load_valid = 1'b1;
        if_b.load_data  = d;
        tick();
        if_b.load_valid = 1'b0;
    endtask

    task automatic start_a();
        if_a.load_start = 1'b1;
        tick();
        if_a.load_start = 1'b0;
    endtask

    task automatic start_b();
        if_b.load_start = 1'b1;
        tick();
        if_b.load_start = 1'b0;
    endtask

    task automatic pulse_commit_a();
        commit_a = 1'b1;
        tick();
        commit_a = 1'b0;
    endtask

    task automatic test_reset();
        reset_a = 1'b1;
        reset_b = 1'b1;
        tick();
        tick();
        reset_a = 1'b0;
        reset_b = 1'b0;
        checks++; if (all_a !== 64'h0) begin errors++; $display("FAIL reset_all got %h exp %h", all_a, 64'h0); end
        for (int i = 0; i < 4; i++) begin
            addr_a = 2'(i);
            #1;
            checks++; if (dout_a !== 16'h0) begin errors++; $display("FAIL reset_dout[%0d] got %h exp 0000", i, dout_a); end
        end
        checks++; if (if_a.load_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", if_a.load_ready); end
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done_a); end
        checks++; if (count_a !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count_a); end
        checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", ovf_a); end
        $display("test_reset done");
    endtask

    task automatic test_continuous_load();
        logic [7:0] bytes [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        start_a();
        checks++; if (if_a.load_ready !== 1'b1) begin errors++; $display("FAIL cont_ready got %b exp 1", if_a.load_ready); end
        for (int i = 0; i < 8; i++) send_a(bytes[i]);
        checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL cont_done got %b exp 1", done_a); end
        checks++; if (count_a !== 3'd4) begin errors++; $display("FAIL cont_count got %0d exp 4", count_a); end
        checks++; if (if_a.load_ready !== 1'b0) begin errors++; $display("FAIL cont_ready_fall got %b exp 0", if_a.load_ready); end
        checks++; if (all_a !== 64'h0) begin errors++; $display("FAIL cont_all_precommit got %h exp 0", all_a); end
        pulse_commit_a();
        addr_a = 2'd1;
        #1;
        checks++; if (dout_a !== 16'h4433) begin errors++; $display("FAIL cont_dout1 got %h exp 4433", dout_a); end
        checks++; if (all_a !== 64'h8877_6655_4433_2211) begin errors++; $display("FAIL cont_all got %h exp 8877665544332211", all_a); end
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL cont_done_clear got %b exp 0", done_a); end
        $display("test_continuous_load done");
    endtask

    task automatic test_backpressure();
        start_a();
        for (int i = 0; i < 8; i++) begin
            send_a(8'hA1 + 8'(i));
            if ((i % 2) == 0) tick();
        end
        checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL bp_done got %b exp 1", done_a); end
        if_a.load_valid = 1'b1;
        if_a.load_data  = 8'hFF;
        tick();
        if_a.load_valid = 1'b0;
        checks++; if (ovf_a !== 1'b1) begin errors++; $display("FAIL bp_ovf got %b exp 1", ovf_a); end
        checks++; if (count_a !== 3'd4) begin errors++; $display("FAIL bp_count got %0d exp 4", count_a); end
        checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL bp_done_hold got %b exp 1", done_a); end
        pulse_commit_a();
        checks++; if (all_a !== 64'hA8A7_A6A5_A4A3_A2A1) begin errors++; $display("FAIL bp_all got %h exp a8a7a6a5a4a3a2a1", all_a); end
        $display("test_backpressure done");
    endtask

    task automatic test_restart();
        start_a();
        send_a(8'h51);
        send_a(8'h52);
        send_a(8'h53);
        if_a.load_start = 1'b1;
        if_a.load_valid = 1'b1;
        if_a.load_data  = 8'hAA;
        tick();
        if_a.load_start = 1'b0;
        if_a.load_valid = 1'b0;
        checks++; if (count_a !== 3'd0) begin errors++; $display("FAIL rs_count got %0d exp 0", count_a); end
        checks++; if (if_a.load_ready !== 1'b1) begin errors++; $display("FAIL rs_ready got %b exp 1", if_a.load_ready); end
        for (int i = 1; i <= 8; i++) send_a(8'(i));
        checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL rs_done got %b exp 1", done_a); end
        pulse_commit_a();
        addr_a = 2'd0;
        #1;
        checks++; if (dout_a !== 16'h0201) begin errors++; $display("FAIL rs_word0 got %h exp 0201", dout_a); end
        checks++; if (all_a !== 64'h0807_0605_0403_0201) begin errors++; $display("FAIL rs_all got %h exp 0807060504030201", all_a); end
        checks++; if (ovf_a !== 1'b1) begin errors++; $display("FAIL rs_ovf_sticky got %b exp 1", ovf_a); end
        $display("test_restart done");
    endtask

    task automatic test_commit_gating();
        start_a();
        for (int i = 0; i < 4; i++) send_a(8'hC1 + 8'(i));
        checks++; if (count_a !== 3'd2) begin errors++; $display("FAIL cg_count2 got %0d exp 2", count_a); end
        pulse_commit_a();
        checks++; if (all_a !== 64'h0807_0605_0403_0201) begin errors++; $display("FAIL cg_all_unchanged got %h exp 0807060504030201", all_a); end
        checks++; if (count_a !== 3'd2) begin errors++; $display("FAIL cg_count_hold got %0d exp 2", count_a); end
        checks++; if (if_a.load_ready !== 1'b1) begin errors++; $display("FAIL cg_ready got %b exp 1", if_a.load_ready); end
        for (int i = 4; i < 8; i++) send_a(8'hC1 + 8'(i));
        checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL cg_done got %b exp 1", done_a); end
        commit_a        = 1'b1;
        if_a.load_start = 1'b1;
        tick();
        commit_a        = 1'b0;
        if_a.load_start = 1'b0;
        checks++; if (all_a !== 64'hC8C7_C6C5_C4C3_C2C1) begin errors++; $display("FAIL cg_both_all got %h exp c8c7c6c5c4c3c2c1", all_a); end
        checks++; if (count_a !== 3'd0) begin errors++; $display("FAIL cg_both_count got %0d exp 0", count_a); end
        checks++; if (if_a.load_ready !== 1'b1) begin errors++; $display("FAIL cg_both_ready got %b exp 1", if_a.load_ready); end
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL cg_both_done got %b exp 0", done_a); end
        checks++; if (ovf_a !== 1'b1) begin errors++; $display("FAIL cg_ovf_sticky got %b exp 1", ovf_a); end
        reset_a = 1'b1;
        tick();
        reset_a = 1'b0;
        checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL cg_ovf_reset got %b exp 0", ovf_a); end
        checks++; if (all_a !== 64'h0) begin errors++; $display("FAIL cg_all_reset got %h exp 0", all_a); end
        $display("test_commit_gating done");
    endtask

    task automatic test_reset_mid_load();
        start_b();
        for (int i = 0; i < 5; i++) send_b(8'h10 + 8'(i));
        checks++; if (count_b !== 4'd5) begin errors++; $display("FAIL rml_count5 got %0d exp 5", count_b); end
        reset_b = 1'b1;
        tick();
        reset_b = 1'b0;
        checks++; if (if_b.load_ready !== 1'b0) begin errors++; $display("FAIL rml_ready got %b exp 0", if_b.load_ready); end
        checks++; if (count_b !== 4'd0) begin errors++; $display("FAIL rml_count got %0d exp 0", count_b); end
        checks++; if (all_b !== 80'h0) begin errors++; $display("FAIL rml_all got %h exp 0", all_b); end
        start_b();
        for (int i = 0; i < 10; i++) send_b(8'(i));
        checks++; if (done_b !== 1'b1) begin errors++; $display("FAIL rml_done got %b exp 1", done_b); end
        checks++; if (count_b !== 4'd10) begin errors++; $display("FAIL rml_count10 got %0d exp 10", count_b); end
        commit_b = 1'b1;
        tick();
        commit_b = 1'b0;
        addr_b = 4'd9;
        #1;
        checks++; if (dout_b !== 8'h09) begin errors++; $display("FAIL rml_addr9 got %h exp 09", dout_b); end
        addr_b = 4'd15;
        #1;
        checks++; if (dout_b !== 8'h00) begin errors++; $display("FAIL rml_addr15 got %h exp 00", dout_b); end
        addr_b = 4'd5;
        #1;
        checks++; if (dout_b !== 8'h05) begin errors++; $display("FAIL rml_addr5 got %h exp 05", dout_b); end
        checks++; if (all_b !== 80'h09_08_07_06_05_04_03_02_01_00) begin errors++; $display("FAIL rml_all_final got %h exp 09080706050403020100", all_b); end
        $display("test_reset_mid_load done");
    endtask

    initial begin
        reset_a = 1'b1; reset_b = 1'b1;
        commit_a = 1'b0; commit_b = 1'b0;
        addr_a = '0; addr_b = '0;
        if_a.load_start = 1'b0; if_a.load_valid = 1'b0; if_a.load_data = '0;
        if_b.load_start = 1'b0; if_b.load_valid = 1'b0; if_b.load_data = '0;
        test_reset();
        test_continuous_load();
        test_backpressure();
        test_restart();
        test_commit_gating();
        test_reset_mid_load();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/snn_param_bank_memory.md
Name: snn_param_bank_memory

Overview:
- Double-buffered parameter memory for SNN weights and delays. It holds M words of N bits.
- A narrow W-bit stream loads the shadow bank through a valid/ready handshake, with word assembly and an auto-incrementing write pointer.
- A commit pulse copies the whole shadow bank into the active bank in one cycle. Neuron and delay logic read only the active bank, so they never see a half-loaded set.
- Sits between the SPI/config front end and the synapse/delay datapath.

Parameters:
- M, 10, number of words; M >= 2.
- N, 8, word width in bits.
- W, 8, load-stream chunk width; N must be an integer multiple of W.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset.
- load_start  in  1  pulse: begin or restart a load at word 0.
- load_data  in  W  stream chunk.
- load_valid  in  1  load_data valid.
- load_ready  out  1  block accepts a chunk this cycle.
- commit  in  1  pulse: copy shadow bank to active bank.
- addr  in  $clog2(M)  read address, active bank.
- data_out  out  N  active[addr], combinational.
- all_data_out  out  M*N  active bank flattened; word j at bits [j*N +: N].
- load_count  out  $clog2(M+1)  words written to shadow in the current load.
- load_done  out  1  all M words loaded and awaiting commit.
- overflow_err  out  1  sticky: data offered after the bank was full.

Behaviour:
- Clocking and reset: single clock domain. Reset is synchronous and active-high, port reset, sampled on posedge clk.
- Reset clears every entry of both banks to 0. It also sets state=IDLE, word_ptr=0, chunk_cnt=0, the assembly register to 0, load_ready=0, load_done=0 and overflow_err=0.
- Reset mid-load discards all partial progress.
- CHUNKS = N/W. Chunks are assembled LSB-first: chunk k occupies bits [k*W +: W].
- Transfer: a transfer occurs when load_valid && load_ready at a posedge.
- State IDLE:
  - load_ready=0, load_done=0.
  - load_start -> LOADING with word_ptr=0, chunk_cnt=0.
  - load_valid is ignored and raises no error.
- State LOADING:
  - load_ready=1.
  - On a transfer with chunk_cnt < CHUNKS-1: store the chunk and increment chunk_cnt.
  - On a transfer with chunk_cnt == CHUNKS-1: shadow[word_ptr] <= {load_data, assembled lower chunks} on that same edge, chunk_cnt <= 0, word_ptr++.
  - If that write was to word M-1: go to LOADED and set load_done=1 on the same edge.
  - load_ready falls in the cycle after the final chunk.
- State LOADED:
  - load_ready=0, load_done=1.
  - load_valid=1 sets overflow_err (sticky until reset); the data is dropped.
- Commit:
  - Acts only in LOADED. On the commit edge, active[i] <= shadow[i] for all i.
  - State -> IDLE, load_done -> 0, word_ptr -> 0.
  - The new values appear on data_out and all_data_out in the cycle after the commit edge.
  - commit in IDLE or LOADING is ignored; the active bank is unchanged.
- load_start in LOADING or LOADED:
  - Restarts: word_ptr=0, chunk_cnt=0, load_done=0, state LOADING.
  - Shadow contents are not cleared; they are overwritten as the load proceeds.
  - load_start has priority over a same-cycle transfer; that chunk is dropped.
- commit and load_start in the same cycle in LOADED: both take effect. The active bank receives the shadow, and the state becomes LOADING with a zeroed pointer.
- load_count = word_ptr. It reads M while in LOADED.
- Reads:
  - data_out = active[addr], purely combinational. addr >= M returns 0.
  - all_data_out is purely combinational from the active bank.
  - Loading never changes either read output.
- Latency: shadow write on the edge accepting the last chunk; active update on the commit edge; read latency zero (combinational).

Decomposition:
- Shared package snn_mem_pkg holds:
  - state enum {IDLE, LOADING, LOADED};
  - localparam helpers CHUNKS = N/W and AW = $clog2(M);
  - a width-check function for N % W == 0.
- One sub-module, snn_word_assembler: chunk counter plus assembly register. It emits word and word_valid on the final chunk and clears on restart or reset.
- Bank storage, FSM and commit copy stay in the top module.

Test Plan (M=4, N=16, W=8 unless noted):
- Reset, then read -> all_data_out=0, data_out=0 for addr 0..3, load_ready=0, load_done=0.
- load_start, then stream bytes 0x11,0x22,0x33,0x44,0x55,0x66,0x77,0x88 with continuous valid:
  - load_done=1 the cycle after the 8th transfer, load_count=4;
  - all_data_out still 0.
  - Then commit -> next cycle data_out@addr1=0x4433 and all_data_out=0x8877_6655_4433_2211.
- Backpressure and error:
  - valid toggled 1-0-1 mid-word -> assembly unaffected and words identical to the continuous case;
  - extra valid in LOADED -> overflow_err=1, shadow unchanged, and it persists until reset.
- Restart: after 3 bytes, assert load_start with valid=1 and data 0xAA -> 0xAA dropped, load_count=0; then reload 0x01..0x08 and commit -> word0=0x0201.
- Commit gating: commit during LOADING (load_count=2) -> active unchanged. Simultaneous commit and load_start in LOADED -> active updated and state LOADING with load_count=0.
- M=10, N=8, W=8: reset mid-load (after 5 bytes) -> all banks 0, load_ready=0. A subsequent full load of 0..9 plus commit -> data_out@addr9=9, addr 15 -> 0.
